// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: bus-writable byte FIFO feeding an 8N1 serial shifter.
// Registers: DATA (0), STATUS (1), DIVISOR (2), CTRL (3); registered read data.
module mmio_uart_tx #(
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DIV_DEFAULT = 16'd434,
    parameter int          ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bus_cs,
    input  logic              bus_wr,
    input  logic              bus_rd,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [31:0]       bus_wr_data,
    output logic [31:0]       bus_rd_data,
    output logic              tx,
    output logic              tx_irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [ADDR_W-1:0] OFF_DATA   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] OFF_STATUS = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] OFF_DIV    = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] OFF_CTRL   = ADDR_W'(3);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t           state, state_n;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [15:0]      divisor, div_eff, timer;
    logic [7:0]       shreg;
    logic [2:0]       bit_idx;
    logic             tx_en, ovf;
    logic             wr_cyc, rd_cyc, full, empty, push, pop, ovf_set, ovf_clr, bit_end, tx_n;
    logic [31:0]      rd_mux;
    logic [7:0]       cnt8;
    logic             unused_wr_bits;

    assign wr_cyc  = bus_cs & bus_wr;
    assign rd_cyc  = bus_cs & bus_rd & ~bus_wr;
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign push    = wr_cyc && (bus_addr == OFF_DATA) && !full;
    assign ovf_set = wr_cyc && (bus_addr == OFF_DATA) && full;
    assign ovf_clr = wr_cyc && (bus_addr == OFF_STATUS) && bus_wr_data[3];
    assign div_eff = (divisor < 16'd2) ? 16'd1 : divisor;
    assign bit_end = (timer == 16'd0);
    assign cnt8    = 8'(count);
    assign tx_irq  = empty && (state == S_IDLE);
    assign unused_wr_bits = ^bus_wr_data[31:16];

    // NOTE: FIFO storage has no reset; emptiness is defined by the pointers/count alone.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus_wr_data[7:0];
    end

    // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divisor <= DIV_DEFAULT;
            tx_en   <= 1'b1;
            ovf     <= 1'b0;
        end else begin
            if (wr_cyc && bus_addr == OFF_DIV)  divisor <= bus_wr_data[15:0];
            if (wr_cyc && bus_addr == OFF_CTRL) tx_en   <= bus_wr_data[0];
            if (ovf_set)      ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        tx_n    = 1'b1;
        case (state)
            S_IDLE: begin
                if (!empty && tx_en) begin
                    pop     = 1'b1;
                    state_n = S_START;
                end
            end
            S_START: begin
                tx_n = 1'b0;
                if (bit_end) state_n = S_DATA;
            end
            S_DATA: begin
                tx_n = shreg[0];
                if (bit_end && bit_idx == 3'd7) state_n = S_STOP;
            end
            S_STOP: begin
                if (bit_end) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            timer   <= '0;
            shreg   <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
        end else begin
            state <= state_n;
            tx    <= tx_n;
            if (pop) begin
                shreg   <= mem[rd_ptr];
                timer   <= div_eff - 16'd1;
                bit_idx <= '0;
            end else if (state != S_IDLE) begin
                if (bit_end) begin
                    // Each bit reloads from the live divisor, so a mid-frame write applies at the next bit.
                    timer <= div_eff - 16'd1;
                    if (state == S_DATA) begin
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 3'd1;
                    end
                end else begin
                    timer <= timer - 16'd1;
                end
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus_addr)
            OFF_STATUS: rd_mux = {16'd0, cnt8, 4'd0, ovf, empty, full, state != S_IDLE};
            OFF_DIV:    rd_mux = {16'd0, divisor};
            OFF_CTRL:   rd_mux = {31'd0, tx_en};
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       bus_rd_data <= '0;
        else if (rd_cyc) bus_rd_data <= rd_mux;
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: expected reads and expected serial frames are queued by
// the stimulus and checked by independent read and line monitors.
module tb_mmio_uart_tx;
    logic        clk = 1'b0;
    logic        reset;
    logic        bus_cs, bus_wr, bus_rd;
    logic [4:0]  bus_addr;
    logic [31:0] bus_wr_data;
    logic [31:0] bus_rd_data;
    logic        tx, tx_irq;

    typedef struct {
        logic [7:0] data;
        int         dur_lo;   // start bit and data bits 0..3
        int         dur_hi;   // data bits 4..7 and stop bit
        int         gap;      // required idle cycles before this start bit, -1 = don't care
    } frame_t;

    frame_t      exp_frames[$];
    logic [31:0] rd_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic        ignore_frames = 1'b0;
    logic        in_frame      = 1'b0;

    mmio_uart_tx #(.FIFO_DEPTH(16), .DIV_DEFAULT(16'd434), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .bus_cs(bus_cs), .bus_wr(bus_wr), .bus_rd(bus_rd),
        .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
        .tx(tx), .tx_irq(tx_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Read monitor: a read accepted at a posedge is compared at the following negedge.
    initial begin : read_mon
        forever begin
            @(posedge clk);
            if (!reset && bus_cs && bus_rd && !bus_wr) begin
                @(negedge clk);
                if (rd_q.size() == 0) check("read_expected_queued", 32'(rd_q.size()), 32'd1);
                else                  check("read_data", bus_rd_data, rd_q.pop_front());
            end
        end
    end

    // Line monitor: on a falling edge of tx, pops an expected frame and checks every cycle of it.
    initial begin : frame_mon
        logic   prev;
        int     last_end;
        frame_t f;
        int     start_cyc, mism, dur;
        logic   exp_bit, aborted;
        prev = 1'b1;
        last_end = -1000;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = 1'b1;
            end else if (prev && !tx) begin
                if (exp_frames.size() == 0) begin
                    if (!ignore_frames) check("frame_expected_queued", 32'(exp_frames.size()), 32'd1);
                end else begin
                    in_frame = 1'b1;
                    f = exp_frames.pop_front();
                    start_cyc = cyc;
                    mism = 0;
                    aborted = 1'b0;
                    for (int b = 0; b < 10 && !aborted; b++) begin
                        dur = (b < 5) ? f.dur_lo : f.dur_hi;
                        exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : f.data[b-1];
                        for (int c = 0; c < dur && !aborted; c++) begin
                            if (b != 0 || c != 0) begin
                                @(negedge clk);
                                if (reset) aborted = 1'b1;
                            end
                            if (!aborted && tx !== exp_bit) mism++;
                        end
                    end
                    if (!aborted) begin
                        check($sformatf("frame_0x%02h_bad_cycles", f.data), 32'(mism), 32'd0);
                        if (f.gap >= 0)
                            check($sformatf("frame_0x%02h_idle_gap", f.data), 32'(start_cyc - last_end - 1), 32'(f.gap));
                        last_end = cyc;
                    end
                    in_frame = 1'b0;
                end
            end
            prev = reset ? 1'b1 : tx;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [4:0] addr, input logic [31:0] data);
        bus_cs = 1'b1; bus_wr = 1'b1; bus_rd = 1'b0; bus_addr = addr; bus_wr_data = data;
        @(negedge clk);
        bus_cs = 1'b0; bus_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] addr, input logic [31:0] exp);
        rd_q.push_back(exp);
        bus_cs = 1'b1; bus_wr = 1'b0; bus_rd = 1'b1; bus_addr = addr;
        @(negedge clk);
        bus_cs = 1'b0; bus_rd = 1'b0;
    endtask

    task automatic push_frame(input logic [7:0] d, input int lo, input int hi, input int gap);
        frame_t f;
        f.data = d; f.dur_lo = lo; f.dur_hi = hi; f.gap = gap;
        exp_frames.push_back(f);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_frames.size() != 0 || in_frame) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exp_frames.size()) + 32'(in_frame), 32'd0);
    endtask

    task automatic wait_tx_low(input string name, input int budget);
        int n = 0;
        while (tx !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, tx}, 32'd0);
    endtask

    initial begin : stimulus
        int low_cnt;
        reset = 1'b1; bus_cs = 1'b0; bus_wr = 1'b0; bus_rd = 1'b0;
        bus_addr = '0; bus_wr_data = '0;
        idle(3);
        reset = 1'b0;
        idle(1);

        // Reset state
        bus_read(5'd1, 32'h0000_0004);
        bus_read(5'd2, 32'd434);
        bus_read(5'd3, 32'd1);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_tx_irq", {31'd0, tx_irq}, 32'd1);

        // Single frame 0xA5 at divisor 4
        bus_write(5'd2, 32'd4);
        push_frame(8'hA5, 4, 4, -1);
        bus_write(5'd0, 32'hA5);
        idle(10);
        bus_read(5'd1, 32'h0000_0005);
        check("busy_tx_irq", {31'd0, tx_irq}, 32'd0);
        wait_drain("drain_a5", 200);
        idle(2);
        check("after_a5_tx_irq", {31'd0, tx_irq}, 32'd1);
        bus_read(5'd1, 32'h0000_0004);
        bus_read(5'd0, 32'h0);
        bus_read(5'd9, 32'h0);
        bus_read(5'd2, 32'd4);

        // Fill with TX disabled, overflow, then clear OVF
        bus_write(5'd3, 32'd0);
        for (int i = 0; i <= 16; i++) bus_write(5'd0, 32'(i));
        bus_read(5'd1, 32'h0000_100A);
        bus_write(5'd1, 32'h8);
        bus_read(5'd1, 32'h0000_1002);
        bus_read(5'd3, 32'h0);
        check("full_tx_irq", {31'd0, tx_irq}, 32'd0);
        idle(20);
        check("disabled_tx_idle", {31'd0, tx}, 32'd1);

        // Enable: 16 back-to-back frames 0x00..0x0F
        for (int i = 0; i < 16; i++) push_frame(8'(i), 4, 4, (i == 0) ? -1 : 1);
        bus_write(5'd3, 32'd1);
        idle(2);
        bus_read(5'd1, 32'h0000_0F01);
        wait_drain("drain_burst", 2000);
        idle(2);
        bus_read(5'd1, 32'h0000_0004);
        check("burst_tx_irq", {31'd0, tx_irq}, 32'd1);

        // Divisor change in the middle of data bit 3
        push_frame(8'h3C, 4, 8, -1);
        bus_write(5'd0, 32'h3C);
        wait_tx_low("start_0x3c", 50);
        idle(16);
        bus_write(5'd2, 32'd8);
        wait_drain("drain_3c", 500);
        bus_write(5'd2, 32'd4);
        idle(3);

        // Reset during data bit 5 with three bytes queued
        ignore_frames = 1'b1;
        bus_write(5'd0, 32'h11);
        wait_tx_low("start_0x11", 50);
        bus_write(5'd0, 32'h22);
        bus_write(5'd0, 32'h33);
        bus_write(5'd0, 32'h44);
        idle(22);
        check("pre_reset_tx_bit5", {31'd0, tx}, 32'd0);
        reset = 1'b1;
        #1;
        check("reset_mid_frame_tx", {31'd0, tx}, 32'd1);
        check("reset_mid_frame_tx_irq", {31'd0, tx_irq}, 32'd1);
        idle(3);
        reset = 1'b0;
        ignore_frames = 1'b0;
        bus_read(5'd1, 32'h0000_0004);
        bus_read(5'd2, 32'd434);
        low_cnt = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) low_cnt++;
        end
        check("post_reset_no_frames", 32'(low_cnt), 32'd0);
        check("read_queue_empty", 32'(rd_q.size()), 32'd0);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
